// File: rtl/wavelet_fir_mac.sv
// Sequential FIR filter: one signed multiply-accumulate per tap per cycle.
// Samples enter through a valid/ready pair; each result is held until the consumer takes it.
module wavelet_fir_mac #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int NUM_TAPS = 7,
    localparam int AW      = $clog2(NUM_TAPS),
    localparam int ACC_W   = DATA_W + COEF_W + $clog2(NUM_TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // out_sum is held stable while out_valid is high and out_ready is low.

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [COEF_W-1:0] C_PASS = {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);

    state_t state, state_next;

    logic signed [DATA_W-1:0] x [NUM_TAPS];
    logic signed [COEF_W-1:0] c [NUM_TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [PROD_W-1:0] prod;
    logic [AW-1:0]            tap;
    logic                     accept;
    logic                     last_tap;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_tap  = (tap == LAST_TAP);

    // The one multiplier is shared across taps by muxing the operands with the tap counter.
    assign prod     = x[tap] * c[tap];
    assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MAC;
            MAC:     if (last_tap) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                x[k] <= '0;
                c[k] <= (k == NUM_TAPS/2) ? C_PASS : '0;
            end
            acc     <= '0;
            tap     <= '0;
            out_sum <= '0;
        end else begin
            if ((state == IDLE) && coef_we && (int'(coef_addr) < NUM_TAPS)) begin
                c[coef_addr] <= coef_data;
            end
            if (accept) begin
                x[0] <= in_sample;
                for (int k = 1; k < NUM_TAPS; k++) begin
                    x[k] <= x[k-1];
                end
                acc <= '0;
                tap <= '0;
            end else if (state == MAC) begin
                // The final tap's sum goes straight to out_sum so OUT follows the last MAC cycle.
                acc <= acc_next;
                if (last_tap) begin
                    out_sum <= acc_next;
                end else begin
                    tap <= tap + AW'(1);
                end
            end
        end
    end

endmodule

// File: doc/wavelet_fir_mac.md
WAVELET_FIR_MAC -- requirements
Module: wavelet_fir_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 8, signed coefficient width.
REQ-003 SHALL have parameter NUM_TAPS, default 7, filter length (>=2).
REQ-004 SHALL derive local ACC_W = DATA_W+COEF_W+$clog2(NUM_TAPS) and AW = $clog2(NUM_TAPS).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port in_valid  input  1  in_sample valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a sample.
REQ-009 SHALL have port in_sample  input  DATA_W  signed two's-complement sample.
REQ-010 SHALL have port coef_we  input  1  coefficient write strobe.
REQ-011 SHALL have port coef_addr  input  AW  coefficient index.
REQ-012 SHALL have port coef_data  input  COEF_W  signed coefficient value.
REQ-013 SHALL have port out_valid  output  1  out_sum valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts out_sum.
REQ-015 SHALL have port out_sum  output  ACC_W  signed filter result.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL hold a delay line x[0..NUM_TAPS-1] (x[0] newest) and coefficient bank c[0..NUM_TAPS-1].
REQ-018 SHALL implement FSM states IDLE, MAC, OUT; in_ready = (state==IDLE).
REQ-019 SHALL accept a sample on an edge where in_valid && in_ready: x[0]<=in_sample, x[k]<=x[k-1], acc<=0, tap counter<=0, state->MAC.
REQ-020 SHALL in MAC add sign-extended x[k]*c[k] to acc, one tap per cycle, k=0..NUM_TAPS-1, using a single signed multiplier.
REQ-021 SHALL move MAC->OUT after the NUM_TAPS-th product is accumulated; out_sum<=acc.
REQ-022 SHALL assert out_valid only in OUT, holding out_sum stable until out_valid && out_ready; then state->IDLE.
REQ-023 SHALL, for an accept edge at cycle T, assert out_valid in cycle T+NUM_TAPS+1; with out_ready held high the sustained rate is one sample per NUM_TAPS+2 cycles.
REQ-024 SHALL compute out_sum = sum over k of x[k]*c[k] exactly; ACC_W guarantees no overflow, no saturation or truncation.
REQ-025 SHALL write c[coef_addr]<=coef_data on coef_we only in IDLE; coef_we in MAC/OUT SHALL be ignored.
REQ-026 SHALL ignore coef_we with coef_addr >= NUM_TAPS.
REQ-027 SHALL, on an IDLE edge with both a coefficient write and a sample accept, apply both; the ensuing MAC uses the new coefficient.
REQ-028 SHALL ignore in_valid while not in IDLE; delay line is not modified.
REQ-029 SHALL hold out_sum at its last value outside OUT.

Reset
REQ-030 SHALL, while rst_n low, force state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, acc=0, tap counter=0, all x[k]=0.
REQ-031 SHALL reset coefficients to pass-through: c[NUM_TAPS/2]=2^(COEF_W-1)-1, all others 0.
REQ-032 SHALL abandon any in-progress MAC or pending OUT when rst_n asserts mid-operation; no result for that sample is ever presented.

Verification (DATA_W=8, COEF_W=8, NUM_TAPS=7, ACC_W=19)
REQ-033 SHALL cover default taps: after reset feed 10,0,0,0,0,0,0 -> out_sum 0,0,0,1270,0,0,0.
REQ-034 SHALL cover impulse: write c=1..7 (c[0]=1), feed 1 then six 0 -> out_sum 1,2,3,4,5,6,7; out_valid exactly 8 cycles after each accept.
REQ-035 SHALL cover worst-case sign: all c=-128, feed -128 seven times -> seventh out_sum = 114688.
REQ-036 SHALL cover backpressure: out_ready low 5 cycles in OUT -> out_sum stable, in_ready=0, in_valid pulses and coef_we ignored; out_ready high -> IDLE next cycle.
REQ-037 SHALL cover reset mid-MAC: rst_n low at tap 3 -> out_valid never asserts for that sample, in_ready=1, history zero, default taps restored; next input 10 with zero history yields 0 until it reaches tap 3.
